// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks two WIDTH-bit operands
// LSB first, one bit per clock, behind a start/ready and done-pulse handshake.

module fadder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, r_sum;
  logic             r_carry, r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s, w_fa_c, w_accept, w_last;
  logic [WIDTH-1:0] w_res_next;

  fadder u_fadder (
    .a_i(r_a_sh[0]),
    .b_i(r_b_sh[0]),
    .c_i(r_carry),
    .s_o(w_fa_s),
    .c_o(w_fa_c)
  );

  assign w_accept = (r_state == IDLE) && start_i;
  assign w_last   = (r_state == ADD) && (r_cnt == CW'(WIDTH - 1));
  // Written as shift/or so that WIDTH==1 needs no zero-width slice.
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: next state is defaulted first so no path through the case leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = ADD;
      ADD:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a_i;
      r_b_sh  <= b_i;
      r_carry <= c_i;
      r_cnt   <= '0;
    end else if (r_state == ADD) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_res   <= w_res_next;
      r_carry <= w_fa_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum <= w_res_next;
        r_c   <= w_fa_c;
      end
    end
  end

  assign ready_o = (r_state == IDLE);
  assign busy_o  = (r_state == ADD) || (r_state == DONE);
  assign done_o  = (r_state == DONE);
  assign sum_o   = r_sum;
  assign c_o     = r_c;
endmodule
